multiport_register_file: RTL and testbench
==========================================

MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, register width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, register index width; depth = 2**ADDR_WIDTH.
REQ-003 The block SHALL have parameter NUM_READ, default 2, number of independent read ports.
REQ-004 The block SHALL have parameter ZERO_REG, default 1, entry 0 hardwired to zero when 1.
REQ-005 The block SHALL have parameter BYPASS, default 1, write-to-read forwarding in the same cycle when 1.
REQ-006 The block SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-007 The block SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-008 The block SHALL have port regWrite  input  1  write enable.
REQ-009 The block SHALL have port writeRegister  input  ADDR_WIDTH  write index.
REQ-010 The block SHALL have port writeData  input  DATA_WIDTH  write value.
REQ-011 The block SHALL have port readRegister  input  NUM_READ*ADDR_WIDTH  packed read indices, port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-012 The block SHALL have port readData  output  NUM_READ*DATA_WIDTH  packed read data, port k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-013 The block SHALL have port clearReq  input  1  request a sequential clear of all entries.
REQ-014 The block SHALL have port busy  output  1  high while a sequential clear is in progress.

Function
REQ-015 Reads SHALL be combinational: readData port k = entry[readRegister k], no clock latency.
REQ-016 A write with regWrite=1 in IDLE SHALL update entry[writeRegister] at the rising edge; visible on reads from the following cycle.
REQ-017 With BYPASS=1, a read port whose index equals writeRegister while regWrite=1 in IDLE SHALL return writeData in the same cycle; with BYPASS=0 it SHALL return the stored value.
REQ-018 With ZERO_REG=1, writes to index 0 SHALL be discarded, reads of index 0 SHALL return 0, and bypass SHALL NOT apply to index 0.
REQ-019 All read ports SHALL be independent; any number may address the same entry simultaneously.
REQ-020 Controller SHALL have states IDLE and CLEAR; busy=1 exactly in CLEAR.
REQ-021 IDLE with clearReq=1 at a rising edge SHALL go to CLEAR with pointer = 0 (1 if ZERO_REG=1).
REQ-022 In CLEAR each cycle SHALL write 0 to entry[pointer] and increment pointer; after clearing entry 2**ADDR_WIDTH-1 the state SHALL return to IDLE at that same edge.
REQ-023 A full clear SHALL take 2**ADDR_WIDTH cycles (2**ADDR_WIDTH-1 with ZERO_REG=1); pointer SHALL NOT wrap.
REQ-024 In CLEAR, regWrite SHALL be ignored (no store, no bypass) and clearReq SHALL be ignored.
REQ-025 Simultaneous regWrite and clearReq in IDLE: the write SHALL complete at that edge, then the clear starts and later zeroes it.
REQ-026 Reads during CLEAR SHALL return current array contents (cleared entries read 0).

Reset
REQ-027 rst_n=0 at a rising edge SHALL zero all entries, set state IDLE, pointer 0, busy 0.
REQ-028 Reset mid-clear SHALL abort the clear; block is IDLE with all entries 0 on the next cycle.
REQ-029 After reset all readData SHALL be 0.

Structure
REQ-030 Shared package regfile_pkg SHALL hold default parameter constants and the IDLE/CLEAR state encoding.
REQ-031 One sub-module regfile_read_port (index compare, bypass mux, zero-register mask) SHALL be instantiated NUM_READ times via generate.

Verification (DATA_WIDTH=32, ADDR_WIDTH=5, NUM_READ=2 unless stated)
REQ-032 Reset, then write i+1 to entries 0..15, read pairs (i, i+1) -> entry 0 reads 0, entry i reads i+1 for i=1..15.
REQ-033 regWrite=1, writeRegister=7, writeData=32'h12345678, readRegister port0=7 same cycle -> port0 = 32'h12345678 (BYPASS=1); old value (BYPASS=0).
REQ-034 Fill entries 1..31 with 32'hA5A5A5A5, pulse clearReq -> busy high 31 cycles, ignored write to entry 3 during clear, all entries read 0 after busy falls.
REQ-035 Assert rst_n=0 on 10th clear cycle -> busy 0 next cycle, all entries 0, a subsequent write to entry 5 of 32'hDEADBEEF reads back correctly.
REQ-036 NUM_READ=4, all ports index 9 holding 32'h00000009 -> all four ports read 32'h00000009; write to entry 0 of 32'hFFFFFFFF -> reads 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and controller state encoding for the multiport register file.
package regfile_pkg;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefAddrWidth = 5;
    localparam int unsigned DefNumRead   = 2;
    localparam int unsigned DefZeroReg   = 1;
    localparam int unsigned DefBypass    = 1;

    typedef enum logic {
        StIdle  = 1'b0,
        StClear = 1'b1
    } ctrlState_e;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: zero-register mask, then same-cycle write forwarding.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned ZERO_REG   = DefZeroReg,
    parameter int unsigned BYPASS     = DefBypass
) (
    input  logic [ADDR_WIDTH-1:0] readIndex,
    input  logic [DATA_WIDTH-1:0] storedData,
    input  logic                  writeActive,
    input  logic [ADDR_WIDTH-1:0] writeIndex,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic [DATA_WIDTH-1:0] readData
);

    logic isZeroReg;
    logic bypassHit;

    assign isZeroReg = (ZERO_REG != 0) && (readIndex == '0);
    assign bypassHit = (BYPASS != 0) && writeActive && (writeIndex == readIndex);

    // The zero mask wins so a write aimed at entry 0 is never forwarded.
    always_comb begin
        readData = storedData;
        if (isZeroReg) begin
            readData = '0;
        end else if (bypassHit) begin
            readData = writeData;
        end
    end

endmodule

// File: rtl/multiport_register_file.sv
// Register file with one write port, NUM_READ combinational read ports and a
// sequential clear engine that walks every entry once.
module multiport_register_file
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned NUM_READ   = DefNumRead,
    parameter int unsigned ZERO_REG   = DefZeroReg,
    parameter int unsigned BYPASS     = DefBypass
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           regWrite,
    input  logic [ADDR_WIDTH-1:0]          writeRegister,
    input  logic [DATA_WIDTH-1:0]          writeData,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] readRegister,
    output logic [NUM_READ*DATA_WIDTH-1:0] readData,
    input  logic                           clearReq,
    output logic                           busy
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ClearStart = (ZERO_REG != 0) ? ADDR_WIDTH'(1) : '0;
    localparam logic [ADDR_WIDTH-1:0] LastIndex  = '1;

    ctrlState_e            stateQ, stateD;
    logic [ADDR_WIDTH-1:0] ptrQ, ptrD;
    logic [DATA_WIDTH-1:0] mem [Depth];

    logic idleWrite;
    logic storeWrite;

    assign idleWrite  = (stateQ == StIdle) && regWrite;
    assign storeWrite = idleWrite && !((ZERO_REG != 0) && (writeRegister == '0));
    assign busy       = (stateQ == StClear);

    always_comb begin
        stateD = stateQ;
        ptrD   = ptrQ;
        case (stateQ)
            StIdle: begin
                if (clearReq) begin
                    stateD = StClear;
                    ptrD   = ClearStart;
                end
            end
            StClear: begin
                // The pointer parks on the last index rather than wrapping.
                if (ptrQ == LastIndex) begin
                    stateD = StIdle;
                end else begin
                    ptrD = ptrQ + ADDR_WIDTH'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ <= StIdle;
            ptrQ   <= '0;
        end else begin
            stateQ <= stateD;
            ptrQ   <= ptrD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem[i] <= '0;
            end
        end else if (stateQ == StClear) begin
            mem[ptrQ] <= '0;
        end else if (storeWrite) begin
            mem[writeRegister] <= writeData;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : gReadPort
        regfile_read_port #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH),
            .ZERO_REG  (ZERO_REG),
            .BYPASS    (BYPASS)
        ) uReadPort (
            .readIndex  (readRegister[k*ADDR_WIDTH +: ADDR_WIDTH]),
            .storedData (mem[readRegister[k*ADDR_WIDTH +: ADDR_WIDTH]]),
            .writeActive(idleWrite),
            .writeIndex (writeRegister),
            .writeData  (writeData),
            .readData   (readData[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_multiport_register_file.sv
// Scoreboard bench: three DUT variants (default, no bypass, four read ports) share write traffic.
module tb_multiport_register_file;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         regWrite;
    logic         clearReq;
    logic [4:0]   writeRegister;
    logic [31:0]  writeData;
    logic [9:0]   readRegister;
    logic [19:0]  readRegister4;
    logic [63:0]  readData;
    logic [63:0]  readDataNb;
    logic [127:0] readData4;
    logic         busy;
    logic         busyNb;
    logic         busy4;

    always #5 clk = ~clk;

    multiport_register_file dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .regWrite     (regWrite),
        .writeRegister(writeRegister),
        .writeData    (writeData),
        .readRegister (readRegister),
        .readData     (readData),
        .clearReq     (clearReq),
        .busy         (busy)
    );

    multiport_register_file #(.BYPASS(0)) dutNb (
        .clk          (clk),
        .rst_n        (rst_n),
        .regWrite     (regWrite),
        .writeRegister(writeRegister),
        .writeData    (writeData),
        .readRegister (readRegister),
        .readData     (readDataNb),
        .clearReq     (clearReq),
        .busy         (busyNb)
    );

    multiport_register_file #(.NUM_READ(4)) dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .regWrite     (regWrite),
        .writeRegister(writeRegister),
        .writeData    (writeData),
        .readRegister (readRegister4),
        .readData     (readData4),
        .clearReq     (clearReq),
        .busy         (busy4)
    );

    typedef struct {
        string       tag;
        int          src;
        logic [31:0] exp;
    } expect_t;

    expect_t sbQ[$];
    int vectors     = 0;
    int miscompares = 0;

    task automatic checkEqual(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // src 0/1: default DUT ports, 2: no-bypass port0, 3..6: quad-port DUT, 7..9: busy flags
    function automatic logic [31:0] observe(input int src);
        if (src == 0) return readData[31:0];
        if (src == 1) return readData[63:32];
        if (src == 2) return readDataNb[31:0];
        if (src >= 3 && src <= 6) return readData4[(src-3)*32 +: 32];
        if (src == 7) return {31'b0, busy};
        if (src == 8) return {31'b0, busyNb};
        if (src == 9) return {31'b0, busy4};
        return 'x;
    endfunction

    task automatic pushExpect(input string tag, input int src, input logic [31:0] exp);
        expect_t e;
        e.tag = tag;
        e.src = src;
        e.exp = exp;
        sbQ.push_back(e);
    endtask

    // Compare everything queued for this cycle mid-cycle, then advance one clock edge.
    task automatic step();
        expect_t e;
        @(negedge clk);
        while (sbQ.size() != 0) begin
            e = sbQ.pop_front();
            checkEqual(e.tag, observe(e.src), e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic setReads(input int a0, input int a1);
        readRegister = {5'(a1), 5'(a0)};
    endtask

    task automatic writeReg(input int addr, input logic [31:0] data);
        regWrite      = 1'b1;
        writeRegister = 5'(addr);
        writeData     = data;
        step();
        regWrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected completion within time limit");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        regWrite      = 1'b0;
        clearReq      = 1'b0;
        writeRegister = '0;
        writeData     = '0;
        readRegister  = '0;
        readRegister4 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        setReads(5, 31);
        pushExpect("rst_busy", 7, 32'd0);
        pushExpect("rst_rd0", 0, 32'd0);
        pushExpect("rst_rd1", 1, 32'd0);
        pushExpect("rst_rd4", 3, 32'd0);
        step();

        // Write i+1 to entries 0..15, read back in pairs
        for (int i = 0; i < 16; i++) writeReg(i, 32'(i + 1));
        for (int i = 0; i < 16; i++) begin
            setReads(i, i + 1);
            pushExpect($sformatf("pair_rd0[%0d]", i), 0, (i == 0) ? 32'd0 : 32'(i + 1));
            pushExpect($sformatf("pair_rd1[%0d]", i + 1), 1, (i + 1 <= 15) ? 32'(i + 2) : 32'd0);
            step();
        end

        // Same-cycle forwarding vs stored value
        regWrite      = 1'b1;
        writeRegister = 5'd7;
        writeData     = 32'h12345678;
        setReads(7, 0);
        pushExpect("bypass_hit", 0, 32'h12345678);
        pushExpect("bypass_off_old", 2, 32'd8);
        pushExpect("bypass_other", 1, 32'd0);
        step();
        regWrite = 1'b0;
        pushExpect("after_write", 0, 32'h12345678);
        pushExpect("after_write_nb", 2, 32'h12345678);
        step();
        regWrite      = 1'b1;
        writeRegister = 5'd0;
        writeData     = 32'hFFFFFFFF;
        setReads(0, 0);
        pushExpect("zero_no_bypass0", 0, 32'd0);
        pushExpect("zero_no_bypass1", 1, 32'd0);
        step();
        regWrite = 1'b0;

        // Fill, then sequential clear with a simultaneous write at its start
        for (int i = 1; i < 32; i++) writeReg(i, 32'hA5A5A5A5);
        clearReq      = 1'b1;
        regWrite      = 1'b1;
        writeRegister = 5'd2;
        writeData     = 32'd77;
        setReads(0, 0);
        pushExpect("clr_pre_busy", 7, 32'd0);
        step();
        clearReq = 1'b0;
        regWrite = 1'b0;
        for (int c = 1; c <= 31; c++) begin
            setReads(c, c - 1);
            if (c == 5) clearReq = 1'b1;
            if (c == 10) begin
                regWrite      = 1'b1;
                writeRegister = 5'd3;
                writeData     = 32'h00001234;
                setReads(10, 3);
            end
            pushExpect($sformatf("clr_busy[%0d]", c), 7, 32'd1);
            pushExpect($sformatf("clr_rd0[%0d]", c), 0, (c == 2) ? 32'd77 : 32'hA5A5A5A5);
            pushExpect($sformatf("clr_rd1[%0d]", c), 1, 32'd0);
            step();
            regWrite = 1'b0;
            clearReq = 1'b0;
        end
        pushExpect("clr_done_busy", 7, 32'd0);
        pushExpect("clr_done_busy_nb", 8, 32'd0);
        for (int i = 0; i < 16; i++) begin
            setReads(2 * i, 2 * i + 1);
            pushExpect($sformatf("swept_rd0[%0d]", 2 * i), 0, 32'd0);
            pushExpect($sformatf("swept_rd1[%0d]", 2 * i + 1), 1, 32'd0);
            step();
        end

        // Reset in the middle of a clear
        writeReg(20, 32'hCAFEF00D);
        writeReg(31, 32'h0BADBEEF);
        clearReq = 1'b1;
        step();
        clearReq = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            pushExpect($sformatf("abort_busy[%0d]", c), 7, 32'd1);
            step();
        end
        rst_n = 1'b0;
        setReads(20, 31);
        pushExpect("abort_busy[10]", 7, 32'd1);
        pushExpect("abort_pre_rd0", 0, 32'hCAFEF00D);
        pushExpect("abort_pre_rd1", 1, 32'h0BADBEEF);
        step();
        rst_n = 1'b1;
        pushExpect("abort_busy_after", 7, 32'd0);
        pushExpect("abort_rd0", 0, 32'd0);
        pushExpect("abort_rd1", 1, 32'd0);
        step();
        writeReg(5, 32'hDEADBEEF);
        setReads(5, 0);
        pushExpect("post_abort_write", 0, 32'hDEADBEEF);
        step();

        // Four read ports on one entry, and the zero register on all four
        writeReg(9, 32'h00000009);
        readRegister4 = {4{5'd9}};
        for (int p = 0; p < 4; p++) pushExpect($sformatf("quad_rd%0d", p), 3 + p, 32'h9);
        step();
        regWrite      = 1'b1;
        writeRegister = 5'd0;
        writeData     = 32'hFFFFFFFF;
        readRegister4 = '0;
        for (int p = 0; p < 4; p++) pushExpect($sformatf("quad_zero_wr%0d", p), 3 + p, 32'd0);
        step();
        regWrite = 1'b0;
        for (int p = 0; p < 4; p++) pushExpect($sformatf("quad_zero%0d", p), 3 + p, 32'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
